// File: rtl/cdb_arbiter.sv
// cdb_arbiter: rss and lsb result FIFOs sharing one registered ROB write-back bus, round-robin arbitrated.
// Define CDB_ARB_BYPASS_EN to let a request into an empty FIFO compete in its arrival cycle.
module cdb_arbiter #(
  parameter int ID_W  = 4,
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            reset_from_rob_bus,
  input  logic [ID_W-1:0] dest_from_rss,
  input  logic [XLEN-1:0] value_from_rss,
  input  logic [XLEN-1:0] next_pc_from_rss,
  output logic            full_to_rss,
  input  logic [ID_W-1:0] dest_from_lsb,
  input  logic [XLEN-1:0] value_from_lsb,
  output logic            full_to_lsb,
  output logic [ID_W-1:0] dest_to_rob,
  output logic [XLEN-1:0] value_to_rob,
  output logic [XLEN-1:0] next_pc_to_rob,
  output logic            src_is_lsb_to_rob
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic SRC_RSS = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic [ID_W-1:0] rss_dest_mem [DEPTH];
  logic [XLEN-1:0] rss_val_mem  [DEPTH];
  logic [XLEN-1:0] rss_npc_mem  [DEPTH];
  logic [ID_W-1:0] lsb_dest_mem [DEPTH];
  logic [XLEN-1:0] lsb_val_mem  [DEPTH];

  logic [PW-1:0] rss_wp, rss_rp, lsb_wp, lsb_rp;
  logic [CW-1:0] rss_cnt, lsb_cnt;
  logic          rr_last;

  logic rss_req, lsb_req;
  logic rss_head_vld, lsb_head_vld;
  logic rss_byp, lsb_byp;
  logic rss_cand, lsb_cand;
  logic grant_rss, grant_lsb;
  logic rss_push, rss_pop, lsb_push, lsb_pop;

  logic [ID_W-1:0] win_dest;
  logic [XLEN-1:0] win_val;
  logic [XLEN-1:0] win_npc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_to_rss = !rdy || (rss_cnt == CNT_FULL);
  assign full_to_lsb = !rdy || (lsb_cnt == CNT_FULL);

  assign rss_req = rdy && (dest_from_rss != '0) && !full_to_rss;
  assign lsb_req = rdy && (dest_from_lsb != '0) && !full_to_lsb;

  assign rss_head_vld = (rss_cnt != '0);
  assign lsb_head_vld = (lsb_cnt != '0);

`ifdef CDB_ARB_BYPASS_EN
  assign rss_byp = rss_req && !rss_head_vld;
  assign lsb_byp = lsb_req && !lsb_head_vld;
`else
  assign rss_byp = 1'b0;
  assign lsb_byp = 1'b0;
`endif

  assign rss_cand = rdy && (rss_head_vld || rss_byp);
  assign lsb_cand = rdy && (lsb_head_vld || lsb_byp);

  // On a tie the source that did not win last time goes first.
  assign grant_rss = rss_cand && (!lsb_cand || (rr_last == SRC_LSB));
  assign grant_lsb = lsb_cand && !grant_rss;

  assign rss_pop  = grant_rss && rss_head_vld;
  assign lsb_pop  = grant_lsb && lsb_head_vld;
  assign rss_push = rss_req && !(grant_rss && rss_byp);
  assign lsb_push = lsb_req && !(grant_lsb && lsb_byp);

  always_comb begin
    win_dest = '0;
    win_val  = '0;
    win_npc  = '0;
    if (grant_rss) begin
      if (rss_head_vld) begin
        win_dest = rss_dest_mem[rss_rp];
        win_val  = rss_val_mem[rss_rp];
        win_npc  = rss_npc_mem[rss_rp];
      end else begin
        win_dest = dest_from_rss;
        win_val  = value_from_rss;
        win_npc  = next_pc_from_rss;
      end
    end else if (grant_lsb) begin
      if (lsb_head_vld) begin
        win_dest = lsb_dest_mem[lsb_rp];
        win_val  = lsb_val_mem[lsb_rp];
      end else begin
        win_dest = dest_from_lsb;
        win_val  = value_from_lsb;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (rss_push) begin
      rss_dest_mem[rss_wp] <= dest_from_rss;
      rss_val_mem[rss_wp]  <= value_from_rss;
      rss_npc_mem[rss_wp]  <= next_pc_from_rss;
    end
    if (lsb_push) begin
      lsb_dest_mem[lsb_wp] <= dest_from_lsb;
      lsb_val_mem[lsb_wp]  <= value_from_lsb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rss_wp            <= '0;
      rss_rp            <= '0;
      rss_cnt           <= '0;
      lsb_wp            <= '0;
      lsb_rp            <= '0;
      lsb_cnt           <= '0;
      rr_last           <= SRC_LSB;
      dest_to_rob       <= '0;
      value_to_rob      <= '0;
      next_pc_to_rob    <= '0;
      src_is_lsb_to_rob <= 1'b0;
    end else if (reset_from_rob_bus) begin
      rss_wp            <= '0;
      rss_rp            <= '0;
      rss_cnt           <= '0;
      lsb_wp            <= '0;
      lsb_rp            <= '0;
      lsb_cnt           <= '0;
      rr_last           <= SRC_LSB;
      dest_to_rob       <= '0;
      value_to_rob      <= '0;
      next_pc_to_rob    <= '0;
      src_is_lsb_to_rob <= 1'b0;
    end else if (rdy) begin
      if (rss_push) rss_wp <= ptr_inc(rss_wp);
      if (rss_pop)  rss_rp <= ptr_inc(rss_rp);
      if (lsb_push) lsb_wp <= ptr_inc(lsb_wp);
      if (lsb_pop)  lsb_rp <= ptr_inc(lsb_rp);
      rss_cnt <= rss_cnt + CW'(rss_push) - CW'(rss_pop);
      lsb_cnt <= lsb_cnt + CW'(lsb_push) - CW'(lsb_pop);
      if (grant_rss || grant_lsb) begin
        dest_to_rob       <= win_dest;
        value_to_rob      <= win_val;
        next_pc_to_rob    <= win_npc;
        src_is_lsb_to_rob <= grant_lsb;
        rr_last           <= grant_lsb ? SRC_LSB : SRC_RSS;
      end else begin
        dest_to_rob <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: per-source expected-result queues filled at accepted pushes and drained from the ROB bus.
// Honours CDB_ARB_BYPASS_EN for latency and arbitration-order expectations.
module tb_cdb_arbiter;

`ifdef CDB_ARB_BYPASS_EN
  localparam int          LAT        = 1;
  localparam logic [3:0]  FROZEN_ID  = 4'd5;
  localparam logic [31:0] FROZEN_VAL = 32'h805;
`else
  localparam int          LAT        = 2;
  localparam logic [3:0]  FROZEN_ID  = 4'd1;
  localparam logic [31:0] FROZEN_VAL = 32'h601;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        reset_from_rob_bus = 1'b0;
  logic [3:0]  dest_from_rss = '0;
  logic [31:0] value_from_rss = '0;
  logic [31:0] next_pc_from_rss = '0;
  logic        full_to_rss;
  logic [3:0]  dest_from_lsb = '0;
  logic [31:0] value_from_lsb = '0;
  logic        full_to_lsb;
  logic [3:0]  dest_to_rob;
  logic [31:0] value_to_rob;
  logic [31:0] next_pc_to_rob;
  logic        src_is_lsb_to_rob;

  always #5 clk = ~clk;

  cdb_arbiter #(.ID_W(4), .XLEN(32), .DEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (reset_from_rob_bus),
    .dest_from_rss      (dest_from_rss),
    .value_from_rss     (value_from_rss),
    .next_pc_from_rss   (next_pc_from_rss),
    .full_to_rss        (full_to_rss),
    .dest_from_lsb      (dest_from_lsb),
    .value_from_lsb     (value_from_lsb),
    .full_to_lsb        (full_to_lsb),
    .dest_to_rob        (dest_to_rob),
    .value_to_rob       (value_to_rob),
    .next_pc_to_rob     (next_pc_to_rob),
    .src_is_lsb_to_rob  (src_is_lsb_to_rob)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] val;
    logic [31:0] npc;
  } exp_t;

  exp_t       rss_q[$];
  exp_t       lsb_q[$];
  logic [3:0] bus_log[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A bus result is consumed by the ROB at the next edge when rdy is high and no flush.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && rdy && !reset_from_rob_bus) begin
      check("rss_req_while_full", 32'(full_to_rss && (dest_from_rss != 0)), 32'd0);
      check("lsb_req_while_full", 32'(full_to_lsb && (dest_from_lsb != 0)), 32'd0);
      if (dest_to_rob != 0) begin
        bus_log.push_back(dest_to_rob);
        if (src_is_lsb_to_rob) begin
          if (lsb_q.size() == 0) check("lsb_spurious", 32'(dest_to_rob), 32'd0);
          else begin
            e = lsb_q.pop_front();
            check("lsb_dest", 32'(dest_to_rob), 32'(e.dest));
            check("lsb_val", value_to_rob, e.val);
            check("lsb_npc", next_pc_to_rob, 32'd0);
          end
        end else begin
          if (rss_q.size() == 0) check("rss_spurious", 32'(dest_to_rob), 32'd0);
          else begin
            e = rss_q.pop_front();
            check("rss_dest", 32'(dest_to_rob), 32'(e.dest));
            check("rss_val", value_to_rob, e.val);
            check("rss_npc", next_pc_to_rob, e.npc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dest_from_rss = '0;
    value_from_rss = '0;
    next_pc_from_rss = '0;
    dest_from_lsb = '0;
    value_from_lsb = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) step();
  endtask

  // Presents a request only when the source is not full; expectation queued only if it will be taken.
  task automatic drive(input logic [3:0] rd, input logic [31:0] rv, input logic [31:0] rn,
                       input logic [3:0] ld, input logic [31:0] lv,
                       output logic acc_r, output logic acc_l);
    exp_t e;
    acc_r = 1'b0;
    acc_l = 1'b0;
    clear_inputs();
    if (rd != 0 && !full_to_rss) begin
      dest_from_rss = rd;
      value_from_rss = rv;
      next_pc_from_rss = rn;
      acc_r = !reset_from_rob_bus;
      if (acc_r) begin
        e.dest = rd; e.val = rv; e.npc = rn;
        rss_q.push_back(e);
      end
    end
    if (ld != 0 && !full_to_lsb) begin
      dest_from_lsb = ld;
      value_from_lsb = lv;
      acc_l = !reset_from_rob_bus;
      if (acc_l) begin
        e.dest = ld; e.val = lv; e.npc = '0;
        lsb_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [3:0] rd, input logic [31:0] rv, input logic [31:0] rn,
                      input logic [3:0] ld, input logic [31:0] lv);
    logic ar, al;
    drive(rd, rv, rn, ld, lv, ar, al);
    step();
    clear_inputs();
  endtask

  task automatic check_order(input string tag, input int n,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] ids [4];
    ids[0] = e0; ids[1] = e1; ids[2] = e2; ids[3] = e3;
    check({tag, "_len"}, 32'(bus_log.size()), 32'(n));
    for (int i = 0; i < n && i < bus_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(bus_log[i]), 32'(ids[i]));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_rss_left"}, 32'(rss_q.size()), 32'd0);
    check({tag, "_lsb_left"}, 32'(lsb_q.size()), 32'd0);
  endtask

  initial begin
    logic       ar, al, saw_fr, saw_fl;
    logic [3:0] nr;
    logic [31:0] lval;

    // Reset held from power-up, released mid-cycle.
    #1 rst = 1'b1; rdy = 1'b1;
    #1;
    check("rst_dest", 32'(dest_to_rob), 32'd0);
    check("rst_val", value_to_rob, 32'd0);
    check("rst_npc", next_pc_to_rob, 32'd0);
    check("rst_src", 32'(src_is_lsb_to_rob), 32'd0);
    check("rst_full_rss", 32'(full_to_rss), 32'd0);
    check("rst_full_lsb", 32'(full_to_lsb), 32'd0);
    #10 rst = 1'b0;
    step();

    // Single rss result and its latency.
    send(4'd3, 32'h11, 32'h104, 4'd0, 32'h0);
    repeat (LAT - 1) step();
    check("t2_dest", 32'(dest_to_rob), 32'd3);
    check("t2_val", value_to_rob, 32'h11);
    check("t2_npc", next_pc_to_rob, 32'h104);
    check("t2_src", 32'(src_is_lsb_to_rob), 32'd0);
    step();
    check("t2_idle", 32'(dest_to_rob), 32'd0);
    check_empty("t2");

    // Flush drops buffered and same-cycle requests and restores rss priority.
    idle(2);
    bus_log.delete();
    drive(4'd1, 32'h601, 32'h701, 4'd9, 32'h809, ar, al);
    step();
    reset_from_rob_bus = 1'b1;
    drive(4'd2, 32'h602, 32'h702, 4'd0, 32'h0, ar, al);
    step();
    reset_from_rob_bus = 1'b0;
    clear_inputs();
    rss_q.delete();
    lsb_q.delete();
    check("t5_dest", 32'(dest_to_rob), 32'd0);
    check("t5_full_rss", 32'(full_to_rss), 32'd0);
    check("t5_full_lsb", 32'(full_to_lsb), 32'd0);
    idle(4);
    send(4'd4, 32'h604, 32'h704, 4'd10, 32'h80a);
    idle(5);
    check_order("t5_order", 2, 4'd4, 4'd10, 4'd0, 4'd0);
    check_empty("t5");

    // Contention: back-to-back requests from both producers.
    idle(1);
    bus_log.delete();
    send(4'd1, 32'h601, 32'h701, 4'd5, 32'h805);
    send(4'd2, 32'h602, 32'h702, 4'd6, 32'h806);
`ifndef CDB_ARB_BYPASS_EN
    check("t3_full_lsb", 32'(full_to_lsb), 32'd1);
    check("t3_full_rss", 32'(full_to_rss), 32'd0);
`endif
    idle(6);
    check_order("t3_order", 4, 4'd1, 4'd5, 4'd2, 4'd6);
    check_empty("t3");

    // Back-pressure: both producers stream every cycle they are allowed to.
    saw_fr = 1'b0;
    saw_fl = 1'b0;
    nr = 4'd1;
    lval = 32'd100;
    for (int i = 0; i < 24; i++) begin
      if (full_to_rss) saw_fr = 1'b1;
      if (full_to_lsb) saw_fl = 1'b1;
      drive(nr, 32'h1000 + 32'(nr), 32'h2000 + 32'(i), 4'd7, lval, ar, al);
      if (ar) nr = (nr == 4'd15) ? 4'd1 : nr + 4'd1;
      if (al) lval = lval + 32'd1;
      step();
    end
    idle(10);
    check("t4_saw_full_rss", 32'(saw_fr), 32'd1);
    check("t4_saw_full_lsb", 32'(saw_fl), 32'd1);
    check_empty("t4");

    // rdy low freezes outputs and blocks producers; drain order preserved.
    reset_from_rob_bus = 1'b1;
    step();
    reset_from_rob_bus = 1'b0;
    idle(2);
    bus_log.delete();
    send(4'd1, 32'h601, 32'h701, 4'd5, 32'h805);
    send(4'd2, 32'h602, 32'h702, 4'd6, 32'h806);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t6_frozen_dest", 32'(dest_to_rob), 32'(FROZEN_ID));
      check("t6_frozen_val", value_to_rob, FROZEN_VAL);
      check("t6_full_rss", 32'(full_to_rss), 32'd1);
      check("t6_full_lsb", 32'(full_to_lsb), 32'd1);
      step();
    end
    rdy = 1'b1;
    idle(8);
    check_order("t6_order", 4, 4'd1, 4'd5, 4'd2, 4'd6);
    check_empty("t6");

    // Asynchronous reset pulse mid-cycle while a result is on the bus.
    send(4'd3, 32'h33, 32'h133, 4'd0, 32'h0);
    repeat (LAT - 1) step();
    check("t1_pre_dest", 32'(dest_to_rob), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("t1_dest", 32'(dest_to_rob), 32'd0);
    check("t1_val", value_to_rob, 32'd0);
    check("t1_npc", next_pc_to_rob, 32'd0);
    check("t1_src", 32'(src_is_lsb_to_rob), 32'd0);
    rst = 1'b0;
    rss_q.delete();
    lsb_q.delete();
    step();
    check("t1_full_rss", 32'(full_to_rss), 32'd0);
    check("t1_full_lsb", 32'(full_to_lsb), 32'd0);
    idle(3);
    check_empty("t1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
